// File: rtl/vga_pkg.sv
// Shared types and default window geometry for the VGA scan-side blocks.
package vga_pkg;

    typedef logic [23:0] rgb_t;

    localparam int VGA_IMG_X0   = 120;
    localparam int VGA_IMG_Y0   = 40;
    localparam int VGA_IMG_W    = 400;
    localparam int VGA_INT_X0   = 220;
    localparam int VGA_INT_Y0   = 140;
    localparam int VGA_INT_W    = 200;
    localparam int VGA_INT_BASE = 160000;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_RUN
    } fetch_state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       win;
        logic       mode;
    } pix_tag_t;

    function automatic logic in_span(
        input logic [9:0] v,
        input logic [9:0] lo,
        input logic [9:0] w
    );
        return (v >= lo) && ((v - lo) < w);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register used to carry raster tags past the RAM latency.
module vga_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (en_i) begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_frame_fetch.sv
// Frame-buffer address generator with latency-matched raster/pixel outputs.
// Define FETCH_CHECKSUM_EN to add the frame_sum running-XOR output.
module vga_frame_fetch
    import vga_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int RD_LATENCY = 2,
    parameter int IMG_X0     = VGA_IMG_X0,
    parameter int IMG_Y0     = VGA_IMG_Y0,
    parameter int IMG_W      = VGA_IMG_W,
    parameter int INT_X0     = VGA_INT_X0,
    parameter int INT_Y0     = VGA_INT_Y0,
    parameter int INT_W      = VGA_INT_W,
    parameter int INT_BASE   = VGA_INT_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_tick,
    input  logic [9:0]        x_in,
    input  logic [9:0]        y_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  rgb_t              rd_data,
    output logic [9:0]        x_out,
    output logic [9:0]        y_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              in_win_out,
    output rgb_t              data_ram,
`ifdef FETCH_CHECKSUM_EN
    output rgb_t              data_interpolado,
    output rgb_t              frame_sum
`else
    output rgb_t              data_interpolado
`endif
);

    localparam logic [9:0] NX0 = 10'(IMG_X0);
    localparam logic [9:0] NY0 = 10'(IMG_Y0);
    localparam logic [9:0] NW  = 10'(IMG_W);
    localparam logic [9:0] NXL = 10'(IMG_X0 + IMG_W - 1);
    localparam logic [9:0] IX0 = 10'(INT_X0);
    localparam logic [9:0] IY0 = 10'(INT_Y0);
    localparam logic [9:0] IW  = 10'(INT_W);
    localparam logic [9:0] IXL = 10'(INT_X0 + INT_W - 1);

    localparam logic [ADDR_W-1:0] NSTEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ISTEP = ADDR_W'(INT_W);
    localparam logic [ADDR_W-1:0] IBASE = ADDR_W'(INT_BASE);

    fetch_state_t      state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        col_q, col_d;

    logic              frame_start, mode_e, run_e, win;
    logic [ADDR_W-1:0] row_e, addr_now, base, row_step;
    logic [9:0]        col_e, x0, y0, w, xl;
    pix_tag_t          tag_in, tag_dl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            mode_q     <= 1'b0;
            row_base_q <= '0;
            col_q      <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        frame_start = pix_tick && (x_in == '0) && (y_in == '0);
        // Frame-start tick already sees the freshly latched mode and cleared counters.
        mode_e = frame_start ? start : mode_q;
        row_e  = frame_start ? '0 : row_base_q;
        col_e  = frame_start ? '0 : col_q;
        run_e  = frame_start || (state_q == FETCH_RUN);

        x0       = mode_e ? IX0 : NX0;
        y0       = mode_e ? IY0 : NY0;
        w        = mode_e ? IW : NW;
        xl       = mode_e ? IXL : NXL;
        base     = mode_e ? IBASE : '0;
        row_step = mode_e ? ISTEP : NSTEP;

        win      = run_e && in_span(x_in, x0, w) && in_span(y_in, y0, w);
        addr_now = base + row_e + ADDR_W'(col_e);

        rd_en   = pix_tick && win && !reset;
        rd_addr = rd_en ? addr_now : addr_q;

        tag_in = '{x: x_in, y: y_in, hs: hsync_in,
                   vs: vsync_in, win: win, mode: mode_e};

        state_d    = state_q;
        mode_d     = mode_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        addr_d     = addr_q;

        if (pix_tick) begin
            unique case (state_q)
                FETCH_IDLE: if (frame_start) state_d = FETCH_RUN;
                FETCH_RUN:  state_d = FETCH_RUN;
                default:    state_d = FETCH_IDLE;
            endcase
            mode_d     = mode_e;
            row_base_d = row_e;
            col_d      = col_e;
            if (win) begin
                addr_d = addr_now;
                if (x_in == xl) begin
                    col_d      = '0;
                    row_base_d = row_e + row_step;
                end else begin
                    col_d = col_e + 10'd1;
                end
            end
        end
    end

    vga_delay_line #(
        .W     ($bits(pix_tag_t)),
        .DEPTH (RD_LATENCY)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en_i  (pix_tick),
        .d_i   (tag_in),
        .q_o   (tag_dl)
    );

    logic [9:0] x_q, y_q;
    logic       hs_q, vs_q, win_q;
    rgb_t       pix_ram_q, pix_int_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            win_q     <= 1'b0;
            pix_ram_q <= '0;
            pix_int_q <= '0;
        end else if (pix_tick) begin
            x_q       <= tag_dl.x;
            y_q       <= tag_dl.y;
            hs_q      <= tag_dl.hs;
            vs_q      <= tag_dl.vs;
            win_q     <= tag_dl.win;
            pix_ram_q <= (tag_dl.win && !tag_dl.mode) ? rd_data : '0;
            pix_int_q <= (tag_dl.win && tag_dl.mode) ? rd_data : '0;
        end
    end

    assign x_out            = x_q;
    assign y_out            = y_q;
    assign hsync_out        = hs_q;
    assign vsync_out        = vs_q;
    assign in_win_out       = win_q;
    assign data_ram         = pix_ram_q;
    assign data_interpolado = pix_int_q;

`ifdef FETCH_CHECKSUM_EN
    rgb_t acc_q, sum_q, acc_d;

    always_comb begin
        acc_d = acc_q ^ (tag_dl.win ? rd_data : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sum_q <= '0;
        end else if (pix_tick) begin
            if (frame_start) begin
                sum_q <= acc_d;
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Self-checking bench for vga_frame_fetch: directed table, spot values and randomized rasters.
module tb_vga_frame_fetch;

    localparam int L = 2;
    localparam int D = L + 1;

    typedef struct {
        int x; int y; bit hs; bit vs; bit win; int dram; int dint;
    } out_t;
    typedef struct { int x; int y; bit st; bit en; int addr; } vec_t;
    typedef struct { bit mode; int x; int y; int val; } spot_t;

    logic        clk = 1'b0;
    logic        reset, pix_tick, hsync_in, vsync_in, start;
    logic        rd_en, hsync_out, vsync_out, in_win_out;
    logic [9:0]  x_in, y_in, x_out, y_out;
    logic [17:0] rd_addr;
    logic [23:0] rd_data, data_ram, data_interpolado;
    logic [23:0] ram_q [L];

    int    checks = 0;
    int    errors = 0;
    out_t  q[$];
    out_t  cur;
    bit    m_run, m_mode, cur_st, first_chk;
    int    m_n, m_last;
    int    spot_mode = -1;
    spot_t spots[6];
    vec_t  tbl[17];

    always #5 clk = ~clk;

    vga_frame_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .pix_tick         (pix_tick),
        .x_in             (x_in),
        .y_in             (y_in),
        .hsync_in         (hsync_in),
        .vsync_in         (vsync_in),
        .start            (start),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .x_out            (x_out),
        .y_out            (y_out),
        .hsync_out        (hsync_out),
        .vsync_out        (vsync_out),
        .in_win_out       (in_win_out),
        .data_ram         (data_ram),
        .data_interpolado (data_interpolado)
    );

    // Frame-buffer model: returns the address as data, L ticks after the strobe.
    always @(posedge clk) begin
        if (pix_tick) begin
            ram_q[0] <= rd_en ? {6'd0, rd_addr} : 24'hBADBAD;
            for (int i = 1; i < L; i++) ram_q[i] <= ram_q[i-1];
        end
    end
    assign rd_data = ram_q[L-1];

    task automatic check(string name, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        out_t z = '{default: 0};
        m_run = 0; m_mode = 0; m_n = 0; m_last = 0;
        q.delete();
        for (int i = 0; i < D - 1; i++) q.push_back(z);
        cur = z;
    endfunction

    task automatic check_outputs(string tag);
        check({tag, "x_out"}, x_out, cur.x);
        check({tag, "y_out"}, y_out, cur.y);
        check({tag, "hsync_out"}, hsync_out, cur.hs);
        check({tag, "vsync_out"}, vsync_out, cur.vs);
        check({tag, "in_win_out"}, in_win_out, cur.win);
        check({tag, "data_ram"}, data_ram, cur.dram);
        check({tag, "data_int"}, data_interpolado, cur.dint);
    endtask

    // One clock: drive inputs, check the strobe/address, then the delayed outputs.
    task automatic step(int x, int y, bit tk, output bit en_dut, output int addr_dut);
        bit   fs, me, win, hs, vs, en;
        int   x0, y0, w, base, n, addr;
        out_t r;
        hs = 1'($urandom);
        vs = 1'($urandom);
        x_in = 10'(x); y_in = 10'(y);
        hsync_in = hs; vsync_in = vs;
        start = cur_st; pix_tick = tk; reset = 1'b0;
        #1;
        en_dut = rd_en;
        addr_dut = int'(rd_addr);
        fs = tk && x == 0 && y == 0;
        me = fs ? cur_st : m_mode;
        if (me) begin x0 = 220; y0 = 140; w = 200; base = 160000; end
        else    begin x0 = 120; y0 = 40;  w = 400; base = 0;      end
        win  = (m_run || fs) && x >= x0 && x < x0 + w && y >= y0 && y < y0 + w;
        n    = fs ? 0 : m_n;
        addr = base + (y - y0) * w + n;
        en   = tk && win;
        check("rd_en", rd_en, en);
        check("rd_addr", rd_addr, en ? addr : m_last);
        if (first_chk && en) begin
            check("first_fetch_addr", rd_addr, 0);
            first_chk = 0;
        end
        if (tk) begin
            m_mode = me;
            m_run  = m_run || fs;
            if (win) begin
                m_last = addr;
                n = (x == x0 + w - 1) ? 0 : n + 1;
            end
            m_n = n;
            r = '{x, y, hs, vs, win, (win && !me) ? addr : 0, (win && me) ? addr : 0};
            q.push_back(r);
            cur = q.pop_front();
        end
        @(posedge clk);
        #1;
        check_outputs("");
        if (tk && spot_mode >= 0) begin
            foreach (spots[i]) begin
                if (int'(spots[i].mode) == spot_mode && spots[i].x == cur.x && spots[i].y == cur.y)
                    check(spots[i].mode ? "spot_data_int" : "spot_data_ram",
                          spots[i].mode ? data_interpolado : data_ram, spots[i].val);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pix_tick = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_outputs("rst_");
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
    endtask

    task automatic tick(int x, int y, bit alt);
        bit e; int a;
        if (alt || $urandom_range(7) == 0)
            step(int'($urandom_range(639)), int'($urandom_range(479)), 1'b0, e, a);
        step(x, y, 1'b1, e, a);
    endtask

    // Sparse raster: window edges and first/last rows in full, random columns elsewhere.
    task automatic frame(bit st, int toggle_y, int reset_y, bit alt);
        int x0, y0, w;
        cur_st = st;
        tick(0, 0, alt);
        if (st) begin x0 = 220; y0 = 140; w = 200; end
        else    begin x0 = 120; y0 = 40;  w = 400; end
        for (int y = y0 - 2; y <= y0 + w + 1; y++) begin
            if (y == toggle_y) cur_st = !st;
            if (y == reset_y) do_reset();
            tick(x0 - 1, y, alt);
            for (int x = x0; x < x0 + w; x++) begin
                if (y == y0 || y == y0 + w - 1 || x == x0 || x == x0 + w - 1 ||
                    $urandom_range(31) == 0)
                    tick(x, y, alt);
            end
            tick(x0 + w, y, alt);
        end
    endtask

    initial begin
        bit e; int a;
        tbl[0]  = '{0,   0,   0, 0, 0};
        tbl[1]  = '{120, 39,  0, 0, 0};
        tbl[2]  = '{119, 40,  0, 0, 0};
        tbl[3]  = '{120, 40,  0, 1, 0};
        tbl[4]  = '{121, 40,  0, 1, 1};
        tbl[5]  = '{519, 40,  0, 1, 2};
        tbl[6]  = '{520, 40,  0, 0, 0};
        tbl[7]  = '{120, 41,  0, 1, 400};
        tbl[8]  = '{519, 41,  0, 1, 401};
        tbl[9]  = '{120, 440, 0, 0, 0};
        tbl[10] = '{0,   0,   1, 0, 0};
        tbl[11] = '{219, 140, 1, 0, 0};
        tbl[12] = '{220, 140, 1, 1, 160000};
        tbl[13] = '{419, 140, 1, 1, 160001};
        tbl[14] = '{220, 141, 1, 1, 160200};
        tbl[15] = '{220, 340, 1, 0, 0};
        tbl[16] = '{420, 141, 1, 0, 0};

        spots[0] = '{0, 120, 40,  0};
        spots[1] = '{0, 519, 40,  399};
        spots[2] = '{0, 120, 41,  400};
        spots[3] = '{0, 519, 439, 159999};
        spots[4] = '{1, 220, 140, 160000};
        spots[5] = '{1, 419, 339, 199999};

        reset = 1'b1; pix_tick = 1'b0; start = 1'b0;
        x_in = '0; y_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        cur_st = 0; first_chk = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_outputs("rst_");
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);

        foreach (tbl[i]) begin
            cur_st = tbl[i].st;
            step(tbl[i].x, tbl[i].y, 1'b1, e, a);
            check("tbl_rd_en", e, tbl[i].en);
            if (tbl[i].en) check("tbl_rd_addr", a, tbl[i].addr);
        end

        spot_mode = 0;
        frame(1'b0, -1, -1, 1'b0);
        spot_mode = 1;
        frame(1'b1, -1, -1, 1'b0);
        spot_mode = 0;
        frame(1'b0, 200, -1, 1'b0);
        spot_mode = 1;
        frame(1'b1, -1, -1, 1'b1);
        spot_mode = -1;
        frame(1'b0, -1, 300, 1'b0);
        spot_mode = 0;
        first_chk = 1;
        frame(1'b0, -1, -1, 1'b0);
        for (int i = 0; i < D + 1; i++) step(5, 5, 1'b1, e, a);
        check("first_fetch_seen", first_chk, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_fetch.md
Name: vga_frame_fetch

Overview:
- Scan-side producer of pixel data for the VGA renderer.
- Takes the raster position and syncs from the VGA timing generator, generates frame-buffer read addresses for the active image window, and absorbs the fixed RAM read latency.
- Presents the returned pixel with the raster position and syncs delayed by the same amount, so the renderer sees coordinates and data aligned.
- Two windows: normal 400x400 image (data_ram) and 200x200 interpolated result (data_interpolado), selected by start.

Parameters:
- ADDR_W, 18, frame-buffer address width.
- RD_LATENCY, 2, pix_tick cycles from rd_en to valid rd_data (1..4).
- IMG_X0, 120, left column of the normal window.
- IMG_Y0, 40, top row of the normal window.
- IMG_W, 400, normal window width and height in pixels.
- INT_X0, 220, left column of the interpolated window.
- INT_Y0, 140, top row of the interpolated window.
- INT_W, 200, interpolated window width and height in pixels.
- INT_BASE, 160000, frame-buffer word address of interpolated pixel (0,0).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pix_tick  in  1  pixel-rate enable; all state advances only when high.
- x_in  in  10  current raster column.
- y_in  in  10  current raster row.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- start  in  1  0 = normal image window, 1 = interpolated window.
- rd_en  out  1  frame-buffer read strobe.
- rd_addr  out  ADDR_W  frame-buffer read address.
- rd_data  in  24  RGB888 word, valid RD_LATENCY ticks after rd_en.
- x_out  out  10  x_in delayed by D = RD_LATENCY+1 ticks.
- y_out  out  10  y_in delayed by D ticks.
- hsync_out  out  1  hsync_in delayed by D ticks.
- vsync_out  out  1  vsync_in delayed by D ticks.
- in_win_out  out  1  delayed pixel lies inside the active window.
- data_ram  out  24  pixel data in normal mode, else 0.
- data_interpolado  out  24  pixel data in interpolated mode, else 0.

Behaviour:
- Reset: all outputs are 0; row_base, col and mode are 0; the delay pipeline is cleared. Reset mid-frame holds outputs at 0. Fetching resumes at the next frame start.
- Frame start is a tick with x_in==0 and y_in==0. On frame start: mode latches start, row_base clears to 0, col clears to 0. start changes mid-frame have no effect until the next frame start (no tearing).
- Window test, evaluated per tick: X0 <= x_in <= X0+W-1 and Y0 <= y_in <= Y0+W-1, using the mode's geometry. Bounds are inclusive; width is exactly W.
- In window: rd_en=1 and rd_addr = base + row_base + col, where base is 0 (mode 0) or INT_BASE (mode 1). col then increments.
- Last column of a window row (x_in==X0+W-1): col returns to 0 and row_base increments by W.
- No multiplier; addresses are generated incrementally. Last pixel of mode 0 = 159999; last pixel of mode 1 = INT_BASE+39999.
- Out of window: rd_en=0 and rd_addr holds its last value.
- Registered outputs, latency D = RD_LATENCY+1 ticks. x/y/syncs/in_win pass through a D-stage shift register. rd_data is registered once on arrival, so it aligns with the delayed coordinates.
- in_win_out=0 forces both data outputs to 0.
- Ticks with pix_tick=0 change nothing. rd_en must be 0 on those cycles.

Optional Feature:
- FETCH_CHECKSUM_EN defined: adds output frame_sum[23:0]. A running XOR of every in-window pixel is captured into frame_sum at each frame start, then the accumulator clears. frame_sum resets to 0.
- Undefined: no port and no logic.

Decomposition:
- Package vga_pkg: 24-bit rgb_t typedef, window geometry constants, INT_BASE.
- Sub-module vga_delay_line (parameterised width and depth, tick-enabled) for the coordinate/sync pipeline.

Test Plan:
- Normal frame, RD_LATENCY=2, RAM model returns data=address: at x_out=120, y_out=40 -> data_ram=0. At (519,40) -> 399. At (120,41) -> 400. At (519,439) -> 159999. data_interpolado=0 throughout.
- start=1 before frame start: at (220,140) -> data_interpolado=160000. At (419,339) -> 199999. data_ram=0. rd_en is never high outside the 200x200 window.
- start toggled at y_in=200 mid-frame -> mode unchanged until the next (0,0) tick; addresses stay continuous.
- Window edges: x_in=119 and x_in=520 -> rd_en=0, in_win_out=0 after D ticks. x_in=120 and x_in=519 -> rd_en=1.
- pix_tick high every other clk -> outputs change only on tick cycles; latency is exactly 3 ticks.
- reset asserted at y_in=300 for 1 clk -> outputs 0. First fetch after the next frame start is address 0.
